// File: rtl/pipelined_rc_adder.sv
// rtl/pipelined_rc_adder.sv - ripple-carry adder/subtractor split into STAGES registered chunks
// with operand skew, sum deskew and a valid/ready handshake that stalls the whole pipe.
module pipelined_rc_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;

  logic              advance;

  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  a_d [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  b_d [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic [WIDTH-1:0]  s_d [STAGES];
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic              ovf_q;
  logic              ovf_d;

  // Stage inputs: stage 0 reads the ports, stage k reads the registers of stage k-1.
  logic [WIDTH-1:0]  src_a [STAGES];
  logic [WIDTH-1:0]  src_b [STAGES];
  logic [WIDTH-1:0]  src_s [STAGES];
  logic [STAGES-1:0] src_c;
  logic [STAGES-1:0] src_v;
  logic [CHUNK:0]    chunk_sum [STAGES];

  always_comb begin
    advance = !valid_q[STAGES-1] || out_ready;

    // Subtraction is a + ~b + 1: b is inverted once on entry and the +1 rides in as carry-in.
    src_a[0] = a;
    src_b[0] = b ^ {WIDTH{sub}};
    src_s[0] = '0;
    src_c[0] = sub | cin;
    src_v[0] = in_valid;
    for (int k = 1; k < STAGES; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = b_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = carry_q[k-1];
      src_v[k] = valid_q[k-1];
    end

    for (int k = 0; k < STAGES; k++) begin
      chunk_sum[k] = {1'b0, src_a[k][k*CHUNK +: CHUNK]}
                   + {1'b0, src_b[k][k*CHUNK +: CHUNK]}
                   + {{CHUNK{1'b0}}, src_c[k]};
      a_d[k]       = src_a[k];
      b_d[k]       = src_b[k];
      s_d[k]       = src_s[k];
      s_d[k][k*CHUNK +: CHUNK] = chunk_sum[k][CHUNK-1:0];
      carry_d[k]   = chunk_sum[k][CHUNK];
      valid_d[k]   = src_v[k];
    end

    // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
    ovf_d = src_a[STAGES-1][WIDTH-1] ^ src_b[STAGES-1][WIDTH-1]
          ^ s_d[STAGES-1][WIDTH-1] ^ carry_d[STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      ovf_q   <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (advance) begin
      valid_q <= valid_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= a_d[k];
        b_q[k] <= b_d[k];
        s_q[k] <= s_d[k];
      end
    end
  end

  assign in_ready  = advance;
  assign out_valid = valid_q[STAGES-1];
  assign s         = s_q[STAGES-1];
  assign cout      = carry_q[STAGES-1];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipelined_rc_adder.sv
// tb/tb_pipelined_rc_adder.sv - randomized and directed self-checking bench for pipelined_rc_adder
// against an arithmetic reference model and an in-order scoreboard.
module tb_pipelined_rc_adder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a_i;
  logic [15:0] b_i;
  logic        cin_i;
  logic        sub_i;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] s_o;
  logic        cout_o;
  logic        ovf_o;

  pipelined_rc_adder #(.WIDTH(16), .STAGES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a_i),
    .b         (b_i),
    .cin       (cin_i),
    .sub       (sub_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s_o),
    .cout      (cout_o),
    .ovf       (ovf_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          n_out    = 0;
  logic [17:0] sb_q [$];
  logic        hold_prev = 1'b0;
  logic [18:0] prev_out;
  logic        done;

  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mcin, input logic msub);
    int   sa;
    int   sbv;
    int   r;
    int   u;
    logic c;
    logic v;
    sa  = int'($signed(ma));
    sbv = int'($signed(mb));
    if (msub) begin
      r = sa - sbv;
      c = (ma >= mb);
    end else begin
      r = sa + sbv + int'(mcin);
      u = int'(ma) + int'(mb) + int'(mcin);
      c = (u > 65535);
    end
    v = (r > 32767) || (r < -32768);
    return {v, c, r[15:0]};
  endfunction

  function automatic logic [15:0] rnd_op();
    case ($urandom % 6)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Compare process: handshakes are decided by values stable at the falling edge.
  always @(negedge clk) begin
    logic [17:0] e;
    if (rst_n) begin
      chk("in_ready_eq_advance", in_ready, !out_valid || out_ready);
      if (hold_prev)
        chk("stall_hold", {out_valid, ovf_o, cout_o, s_o}, prev_out);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("spurious_out_valid", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("s", s_o, e[15:0]);
          chk("cout", cout_o, e[16]);
          chk("ovf", ovf_o, e[17]);
          n_out++;
        end
      end
      if (in_valid && in_ready)
        sb_q.push_back(model(a_i, b_i, cin_i, sub_i));
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_valid, ovf_o, cout_o, s_o};
    end else begin
      hold_prev = 1'b0;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the beat was taken.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb, input logic tc, input logic ts);
    logic acc;
    int   guard;
    a_i = ta; b_i = tb; cin_i = tc; sub_i = ts; in_valid = 1'b1;
    guard = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((sb_q.size() != 0 || out_valid) && guard < 300) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 300) chk("drain_timeout", 0, 1);
  endtask

  task automatic directed(input string name, input logic [15:0] ta, input logic [15:0] tb,
                          input logic tc, input logic ts,
                          input logic [15:0] es, input logic ec, input logic eo);
    int c0;
    int guard;
    wait_drain();
    c0 = cyc;
    send(ta, tb, tc, ts);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!out_valid && guard < 20);
    chk({name, "_latency"}, cyc - c0, 4);
    chk({name, "_s"}, s_o, es);
    chk({name, "_cout"}, cout_o, ec);
    chk({name, "_ovf"}, ovf_o, eo);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int stall_cnt;
    int n0;
    int bad;
    rst_n = 1'b0; in_valid = 1'b0; a_i = '0; b_i = '0; cin_i = 1'b0; sub_i = 1'b0;
    out_ready = 1'b1; done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_s", s_o, 0);
    chk("rst_cout", cout_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("wrap",     16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("posovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed("carry_all",16'h0FFF, 16'h0000, 1'b1, 1'b0, 16'h1000, 1'b0, 1'b0);
    directed("sub_min",  16'h0000, 16'h8000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    directed("neg_ovf",  16'h8000, 16'hFFFF, 1'b0, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Eight back-to-back beats with a three-cycle stall at the first result.
    wait_drain();
    n0 = n_out;
    stall_cnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++)
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
      end
      begin
        int g;
        g = 0;
        do begin
          @(posedge clk);
          #1;
          g++;
        end while (!out_valid && g < 30);
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge clk);
          if (!in_ready && out_valid) stall_cnt++;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_cycles", stall_cnt, 3);
    chk("stall_beats_out", n_out - n0, 8);

    // Random traffic with random backpressure.
    n0 = n_out;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom % 4 == 0) begin
            @(posedge clk);
            #1;
          end
          send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = ($urandom % 10) < 7;
          @(posedge clk);
          #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("random_beats_out", n_out - n0, 300);

    // Reset with beats in flight.
    wait_drain();
    for (int i = 0; i < 3; i++)
      send(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
    @(posedge clk);
    #3;
    chk("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_s", s_o, 0);
    chk("mid_rst_cout", cout_o, 0);
    chk("mid_rst_ovf", ovf_o, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    sb_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) bad++;
    end
    chk("post_rst_no_output", bad, 0);

    directed("after_rst", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
